piso_serializer: RTL and testbench



---
 rtl/shift_reg_pkg.sv | 18 +
 rtl/piso_bit_counter.sv | 24 ++
 rtl/piso_serializer.sv | 127 ++++++++++++
 tb/tb_piso_serializer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the shift-register family (serializer and capture blocks).
// The optional trailing parity bit is built when PISO_PARITY_EN is defined.
package shift_reg_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Bit-counter width: clog2 of the word width, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 32'd2) ? 32'd1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: clear/enable with a terminal-count flag against a last-index input.
module piso_bit_counter #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] last_idx,
  output logic [CW-1:0] count,
  output logic          last
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == last_idx);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned   CW         = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);
`ifdef PISO_PARITY_EN
  localparam bit DONE_ON_DATA = 1'b0;
`else
  localparam bit DONE_ON_DATA = 1'b1;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             final_cycle;
  logic             accept;
  logic             cnt_clear;
  logic             cnt_en;

`ifdef PISO_PARITY_EN
  logic parity_q;
  assign final_cycle = (state == PARITY);
`else
  assign final_cycle = (state == SHIFT) && cnt_last;
`endif

  // load_ready is the only combinational output; it opens in IDLE and on the frame's last bit.
  assign load_ready = !reset && ((state == IDLE) || final_cycle);
  assign accept     = load_valid && load_ready;
  assign cnt_clear  = accept || final_cycle;
  assign cnt_en     = (state == SHIFT) && !cnt_last;

  piso_bit_counter #(
    .CW(CW)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .last_idx (LAST_IDX),
    .count    (cnt),
    .last     (cnt_last)
  );

  // FSM, shift register and registered serial outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (accept) begin
        state        <= SHIFT;
        shreg        <= parallel_in;
        serial_out   <= MSB_FIRST ? parallel_in[WIDTH-1] : parallel_in[0];
        serial_valid <= 1'b1;
        frame_start  <= 1'b1;
        busy         <= 1'b1;
`ifdef PISO_PARITY_EN
        parity_q     <= ^parallel_in;
`endif
      end else begin
        case (state)
          SHIFT: begin
            if (!cnt_last) begin
              shreg      <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
              serial_out <= MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
              frame_done <= DONE_ON_DATA && (cnt == PENULT_IDX);
            end else begin
`ifdef PISO_PARITY_EN
              state      <= PARITY;
              serial_out <= parity_q;
              frame_done <= 1'b1;
`else
              state        <= IDLE;
              serial_out   <= 1'b0;
              serial_valid <= 1'b0;
              busy         <= 1'b0;
`endif
            end
          end
          PARITY: begin
            state        <= IDLE;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            busy         <= 1'b0;
          end
          default: begin
            state        <= IDLE;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances against a frame-level model.
// Honours PISO_PARITY_EN for the expected frame length.
module tb_piso_serializer;

  localparam int unsigned W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk;
  logic         reset;
  logic [W-1:0] parallel_in;
  logic         load_valid;
  logic [1:0]   load_ready, serial_out, serial_valid, frame_start, frame_done, busy;

  int checks   = 0;
  int failures = 0;

  // Model: per instance (0 = MSB first, 1 = LSB first) the frame bits and the bit on the wire.
  logic [W:0] m_bits [2];
  int         m_idx  [2];
  bit         m_act  [2];

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(load_ready[0]), .serial_out(serial_out[0]), .serial_valid(serial_valid[0]),
    .frame_start(frame_start[0]), .frame_done(frame_done[0]), .busy(busy[0])
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(load_ready[1]), .serial_out(serial_out[1]), .serial_valid(serial_valid[1]),
    .frame_start(frame_start[1]), .frame_done(frame_done[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] build_frame(input logic [W-1:0] w, input int m);
    logic [W:0] f;
    f = '0;
    for (int i = 0; i < W; i++) f[i] = (m == 0) ? w[W-1-i] : w[i];
    f[W] = ^w;
    return f;
  endfunction

  task automatic compare_outputs();
    for (int m = 0; m < 2; m++) begin
      logic exp_so, exp_rdy;
      exp_so  = m_act[m] ? m_bits[m][m_idx[m]] : 1'b0;
      exp_rdy = !reset && (!m_act[m] || m_idx[m] == FL - 1);
      check($sformatf("serial_out[%0d]", m),   32'(serial_out[m]),   32'(exp_so));
      check($sformatf("serial_valid[%0d]", m), 32'(serial_valid[m]), 32'(m_act[m]));
      check($sformatf("frame_start[%0d]", m),  32'(frame_start[m]),  32'(m_act[m] && m_idx[m] == 0));
      check($sformatf("frame_done[%0d]", m),   32'(frame_done[m]),   32'(m_act[m] && m_idx[m] == FL - 1));
      check($sformatf("busy[%0d]", m),         32'(busy[m]),         32'(m_act[m]));
      check($sformatf("load_ready[%0d]", m),   32'(load_ready[m]),   32'(exp_rdy));
    end
  endtask

  task automatic model_edge(input logic rst, input logic v, input logic [W-1:0] d);
    for (int m = 0; m < 2; m++) begin
      bit rdy;
      rdy = !rst && (!m_act[m] || m_idx[m] == FL - 1);
      if (rst) begin
        m_act[m] = 1'b0;
        m_idx[m] = 0;
      end else if (v && rdy) begin
        m_bits[m] = build_frame(d, m);
        m_idx[m]  = 0;
        m_act[m]  = 1'b1;
      end else if (m_act[m]) begin
        if (m_idx[m] == FL - 1) m_act[m] = 1'b0;
        else m_idx[m]++;
      end
    end
  endtask

  // Drive inputs for the coming edge, check the current cycle, then advance DUT and model.
  task automatic cycle(input logic rst, input logic v, input logic [W-1:0] d);
    reset       = rst;
    load_valid  = v;
    parallel_in = d;
    #1;
    compare_outputs();
    @(posedge clk);
    model_edge(rst, v, d);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, W'($urandom));
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_bits[m] = '0;
      m_idx[m]  = 0;
      m_act[m]  = 1'b0;
    end
    reset = 1'b1; load_valid = 1'b0; parallel_in = '0;
    @(negedge clk);
    cycle(1'b1, 1'b1, 4'b1111);
    cycle(1'b1, 1'b0, 4'b0000);

    // Single frame of 1011, then idle.
    cycle(1'b0, 1'b1, 4'b1011);
    idle_cycles(FL + 2);

    // Back-to-back: second word held valid until accepted on the last bit.
    cycle(1'b0, 1'b1, 4'b1100);
    for (int i = 0; i < FL; i++) cycle(1'b0, 1'b1, 4'b0011);
    idle_cycles(FL + 1);

    // Mid-frame load pulse is ignored.
    cycle(1'b0, 1'b1, 4'b1011);
    cycle(1'b0, 1'b1, 4'b0110);
    idle_cycles(FL + 1);

    // Reset during bit 2 of a frame, then a fresh load.
    cycle(1'b0, 1'b1, 4'b1011);
    cycle(1'b0, 1'b0, 4'b0000);
    cycle(1'b1, 1'b1, 4'b0000);
    cycle(1'b0, 1'b0, 4'b0000);
    cycle(1'b0, 1'b1, 4'b0110);
    idle_cycles(FL + 1);
    cycle(1'b0, 1'b1, 4'b1100);
    idle_cycles(FL + 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), W'($urandom));
    end
    idle_cycles(FL + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
